parrot_video_timing: RTL and testbench
======================================

# parrot_video_timing

LCD raster timing generator and animation frame sequencer for the PartyParrot core. It runs on `clk36m` and advances one pixel per `ce_pix` enable, which is the 9 MHz strobe from the core clock divider. It produces the sync, data-enable and pixel-strobe signals that drive `lcd_hsync`/`lcd_vsync`/`lcd_de`/`lcd_clk` (CE_PIXEL). It also produces the pixel coordinates and the current parrot frame index consumed by the sprite fetch/RGB565 stage feeding `lcd_data`.

## Interface
- `H_ACTIVE`, 480, visible pixels per line
- `H_FP`, 2, horizontal front porch (pixels)
- `H_SYNC`, 41, hsync width (pixels)
- `H_BP`, 2, horizontal back porch (pixels)
- `V_ACTIVE`, 272, visible lines
- `V_FP`, 2, vertical front porch (lines)
- `V_SYNC`, 10, vsync width (lines)
- `V_BP`, 2, vertical back porch (lines)
- `N_FRAMES`, 10, animation frames (frame_idx wraps at N_FRAMES-1)
- `HOLD_NORMAL`, 4, video frames per animation frame
- `HOLD_FAST`, 1, video frames per animation frame while party-hard is active

Ports:
- `clk36m`  in  1  sole clock
- `i_res_n`  in  1  asynchronous, active-low reset
- `ce_pix`  in  1  pixel enable, one-cycle pulse
- `btn_a`  in  1  party-hard button, active-low, asynchronous
- `btn_b`  in  1  pause button, active-low, asynchronous
- `lcd_clk`  out  1  pixel strobe, 1-cycle pulse
- `lcd_hsync`  out  1  active-low hsync
- `lcd_vsync`  out  1  active-low vsync
- `lcd_de`  out  1  data enable
- `pix_x`  out  9  column, valid when lcd_de
- `pix_y`  out  9  line, valid when lcd_de
- `frame_idx`  out  4  current animation frame
- `frame_start`  out  1  1-cycle pulse coincident with lcd_clk for position (0,0)

## Operation
- Counters: `h_cnt` runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 525. `v_cnt` runs 0..V_TOTAL-1, where V_TOTAL = 286. Both advance only on cycles with ce_pix=1. `h_cnt` wraps to 0 and increments `v_cnt`. `v_cnt` wraps to 0 after V_TOTAL-1.
- Line order: active, front porch, sync, back porch. `lcd_de` = (h<H_ACTIVE && v<V_ACTIVE).
- `lcd_hsync` = 0 for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. `lcd_vsync` = 0 for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], over whole lines.
- `pix_x` = h and `pix_y` = v when `lcd_de`=1. Both are held at 0 when `lcd_de`=0.
- Buttons: each button goes through a 2-FF synchroniser, then is inverted to active-high (`pa`, `pp`).
- Buttons are sampled only at the frame-end event, which gives debouncing to frame rate. Frame-end event = ce_pix && h=H_TOTAL-1 && v=V_TOTAL-1.
- Sequencer state: `hold_cnt` (4 bits) and `frame_idx`. On each frame-end event:
  - If `pp`=1 (pause): no change. Pause wins over party-hard.
  - Otherwise let limit = `pa` ? HOLD_FAST : HOLD_NORMAL.
    - If hold_cnt+1 >= limit: hold_cnt←0, and frame_idx←(frame_idx==N_FRAMES-1) ? 0 : frame_idx+1.
    - Else: hold_cnt←hold_cnt+1.
  - The >= comparison covers a switch from normal to fast while hold_cnt is above HOLD_FAST.

## Timing
- Reset values: lcd_clk=0, lcd_hsync=1, lcd_vsync=1, lcd_de=0, pix_x=0, pix_y=0, frame_idx=0, frame_start=0. Internally h_cnt=0, v_cnt=0, hold_cnt=0, and the synchronisers read "released".
- Output alignment: pixel pulse k is the k-th ce_pix since reset, counting from 0. On the clock edge where pulse k is sampled, all outputs register the decode of the pre-increment (h,v) = (k mod 525, (k div 525) mod 286). Outputs are therefore valid from the next cycle and hold until the edge of pulse k+1.
- `lcd_clk` and `frame_start` are registered copies of the pulse: high exactly one cycle, on the first cycle of new output values. lcd_clk is 0 on every other cycle.
- `frame_idx` updates in the same registered step as the frame-end decode. A new value is first visible together with frame_start for (0,0) of the next frame.
- Latency from button pin to effect: 2 cycles of synchroniser, plus a wait of up to one frame for the next frame-end.
- ce_pix held high continuously is legal: one pixel per clock. ce_pix=0 freezes all state and outputs, except the synchronisers.
- Reset asserted mid-frame: all registers return to their reset values immediately and asynchronously. The first ce_pix after release is pulse 0.

## Test plan
- Reset then release, ce_pix every 4th cycle. Check reset values. After pulse 0: lcd_de=1, pix_x=0, pix_y=0, frame_start=1 for 1 cycle, lcd_clk=1 for 1 cycle.
- One line: pulse 479 gives pix_x=479 with de=1. Pulse 480 gives de=0 and pix_x=0. hsync=0 exactly for pulses 482..522. Pulse 525 gives pix_y=1, pix_x=0, de=1.
- Vertical: vsync=0 exactly for lines 274..283 over full lines. de=0 for lines 272..285. frame_start recurs every 150150 pulses.
- Sequencer with buttons released: frame_idx goes 0→1 after the 4th frame-end. It wraps 9→0 after 40 frame-ends. With btn_a=0, it advances on every frame-end.
- Pause: btn_b=0 held for 8 frames leaves frame_idx and hold_cnt unchanged. btn_a=0 and btn_b=0 together also give no advance. After release, counting resumes from the held hold_cnt.
- Reset pulse mid-line at pulse 1000: outputs return to reset values within the reset cycle. The first pulse after release gives (0,0) and frame_idx=0. Also run with ce_pix tied high and recheck the line-timing checks.

Source files
------------

// File: rtl/parrot_video_timing_if.sv
// LCD raster output bundle: sync, data-enable, pixel strobe, coordinates and frame index.
interface parrot_video_timing_if;
    logic       lcd_clk;
    logic       lcd_hsync;
    logic       lcd_vsync;
    logic       lcd_de;
    logic [8:0] pix_x;
    logic [8:0] pix_y;
    logic [3:0] frame_idx;
    logic       frame_start;

    modport master (
        output lcd_clk, lcd_hsync, lcd_vsync, lcd_de, pix_x, pix_y, frame_idx, frame_start
    );

    modport slave (
        input lcd_clk, lcd_hsync, lcd_vsync, lcd_de, pix_x, pix_y, frame_idx, frame_start
    );
endinterface

// File: rtl/parrot_video_timing.sv
// LCD raster timing generator and party-parrot animation frame sequencer.
// Every output register captures the decode of the pre-increment (h, v) on a ce_pix cycle.
module parrot_video_timing #(
    parameter int unsigned H_ACTIVE    = 480,
    parameter int unsigned H_FP        = 2,
    parameter int unsigned H_SYNC      = 41,
    parameter int unsigned H_BP        = 2,
    parameter int unsigned V_ACTIVE    = 272,
    parameter int unsigned V_FP        = 2,
    parameter int unsigned V_SYNC      = 10,
    parameter int unsigned V_BP        = 2,
    parameter int unsigned N_FRAMES    = 10,
    parameter int unsigned HOLD_NORMAL = 4,
    parameter int unsigned HOLD_FAST   = 1
) (
    input  logic                  clk36m,
    input  logic                  i_res_n,
    input  logic                  ce_pix,
    input  logic                  btn_a,
    input  logic                  btn_b,
    parrot_video_timing_if.master vid
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] HLast      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HActive    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HSyncStart = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HSyncEnd   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VLast      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VActive    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VSyncStart = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VSyncEnd   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [3:0]    FrameLast  = 4'(N_FRAMES - 1);
    localparam logic [4:0]    HoldNormal = 5'(HOLD_NORMAL);
    localparam logic [4:0]    HoldFast   = 5'(HOLD_FAST);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [1:0]    sync_a_q, sync_a_d;
    logic [1:0]    sync_b_q, sync_b_d;
    logic [3:0]    hold_q, hold_d;
    logic [3:0]    frame_cur_q, frame_cur_d;

    logic          lcd_clk_q, lcd_clk_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic [8:0]    pix_x_q, pix_x_d;
    logic [8:0]    pix_y_q, pix_y_d;
    logic [3:0]    frame_idx_q, frame_idx_d;
    logic          frame_start_q, frame_start_d;

    logic          h_last, v_last, frame_end, pa, pp, act;
    logic [4:0]    hold_inc, limit;

    // Next-state for raster counters, output decode, button sync and sequencer
    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        frame_idx_d   = frame_idx_q;
        hold_d        = hold_q;
        frame_cur_d   = frame_cur_q;

        h_last    = (h_q == HLast);
        v_last    = (v_q == VLast);
        frame_end = ce_pix && h_last && v_last;
        act       = (h_q < HActive) && (v_q < VActive);

        // Pins are active-low; sync registers reset to the released level
        sync_a_d = {sync_a_q[0], btn_a};
        sync_b_d = {sync_b_q[0], btn_b};
        pa       = ~sync_a_q[1];
        pp       = ~sync_b_q[1];

        lcd_clk_d     = ce_pix;
        frame_start_d = ce_pix && (h_q == '0) && (v_q == '0);

        if (ce_pix) begin
            h_d = h_last ? '0 : h_q + HW'(1);
            if (h_last) begin
                v_d = v_last ? '0 : v_q + VW'(1);
            end
            de_d    = act;
            hsync_d = !((h_q >= HSyncStart) && (h_q <= HSyncEnd));
            vsync_d = !((v_q >= VSyncStart) && (v_q <= VSyncEnd));
            pix_x_d = act ? 9'(h_q) : 9'd0;
            pix_y_d = act ? 9'(v_q) : 9'd0;
            // frame_cur changed on the frame-end edge, so the copy lands with frame_start
            frame_idx_d = frame_cur_q;
        end

        hold_inc = {1'b0, hold_q} + 5'd1;
        limit    = pa ? HoldFast : HoldNormal;
        // >= so switching to fast with hold above HOLD_FAST still advances immediately
        if (frame_end && !pp) begin
            if (hold_inc >= limit) begin
                hold_d      = '0;
                frame_cur_d = (frame_cur_q == FrameLast) ? 4'd0 : frame_cur_q + 4'd1;
            end else begin
                hold_d = hold_inc[3:0];
            end
        end
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk36m or negedge i_res_n) begin
        if (!i_res_n) begin
            h_q           <= '0;
            v_q           <= '0;
            sync_a_q      <= 2'b11;
            sync_b_q      <= 2'b11;
            hold_q        <= '0;
            frame_cur_q   <= '0;
            lcd_clk_q     <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_idx_q   <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            sync_a_q      <= sync_a_d;
            sync_b_q      <= sync_b_d;
            hold_q        <= hold_d;
            frame_cur_q   <= frame_cur_d;
            lcd_clk_q     <= lcd_clk_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_idx_q   <= frame_idx_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vid.lcd_clk     = lcd_clk_q;
    assign vid.lcd_hsync   = hsync_q;
    assign vid.lcd_vsync   = vsync_q;
    assign vid.lcd_de      = de_q;
    assign vid.pix_x       = pix_x_q;
    assign vid.pix_y       = pix_y_q;
    assign vid.frame_idx   = frame_idx_q;
    assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_parrot_video_timing.sv
// Directed bench: full-size raster for line timing, a shrunken raster for frame/sequencer checks.
module tb_parrot_video_timing;

    logic clk36m = 1'b0;
    logic i_res_n;
    logic ce_pix;
    logic btn_a;
    logic btn_b;

    int checks = 0;
    int errors = 0;

    parrot_video_timing_if full_if ();
    parrot_video_timing_if small_if ();

    parrot_video_timing dut_full (
        .clk36m  (clk36m),
        .i_res_n (i_res_n),
        .ce_pix  (ce_pix),
        .btn_a   (btn_a),
        .btn_b   (btn_b),
        .vid     (full_if)
    );

    // 8 x 6 raster: 48 pulses per video frame
    parrot_video_timing #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1)
    ) dut_small (
        .clk36m  (clk36m),
        .i_res_n (i_res_n),
        .ce_pix  (ce_pix),
        .btn_a   (btn_a),
        .btn_b   (btn_b),
        .vid     (small_if)
    );

    always #5 clk36m = ~clk36m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk36m);
        #1;
    endtask

    task automatic do_pulse(input int gap);
        for (int i = 1; i < gap; i++) begin
            ce_pix = 1'b0;
            tick();
        end
        ce_pix = 1'b1;
        tick();
    endtask

    // Pulses 1..525 on the full raster, assuming pulse 0 was just issued
    task automatic run_line(input int gap);
        int hs_low, first, last, bad_clk;
        hs_low = 0; first = -1; last = -1; bad_clk = 0;
        for (int p = 1; p <= 525; p++) begin
            do_pulse(gap);
            if (full_if.lcd_clk !== 1'b1) bad_clk++;
            if (full_if.lcd_hsync === 1'b0) begin
                hs_low++;
                if (first < 0) first = p;
                last = p;
            end
            if (p == 479) begin
                chk("de_x479", full_if.lcd_de, 1);
                chk("pix_x479", full_if.pix_x, 479);
                ce_pix = 1'b0;
                tick();
                chk("freeze_x479", full_if.pix_x, 479);
                chk("clk_gap", full_if.lcd_clk, 0);
            end
            if (p == 480) begin
                chk("de_x480", full_if.lcd_de, 0);
                chk("pix_x480", full_if.pix_x, 0);
            end
            if (p == 525) begin
                chk("pix_y525", full_if.pix_y, 1);
                chk("pix_x525", full_if.pix_x, 0);
                chk("de525", full_if.lcd_de, 1);
            end
        end
        chk("hs_first", first, 482);
        chk("hs_last", last, 522);
        chk("hs_count", hs_low, 41);
        chk("lcd_clk_each_pulse", bad_clk, 0);
    endtask

    // Run n small-raster frames with ce_pix high, landing on the next frame_start
    task automatic step_frames(input int n, input int exp_idx, input string tag);
        repeat (n * 48) tick();
        chk({tag, "_fs"}, small_if.frame_start, 1);
        chk(tag, small_if.frame_idx, exp_idx);
    endtask

    initial begin
        int vbad, debad, fsbad;
        i_res_n = 1'b0;
        ce_pix  = 1'b0;
        btn_a   = 1'b1;
        btn_b   = 1'b1;
        repeat (3) tick();

        chk("rst_lcd_clk", full_if.lcd_clk, 0);
        chk("rst_hsync", full_if.lcd_hsync, 1);
        chk("rst_vsync", full_if.lcd_vsync, 1);
        chk("rst_de", full_if.lcd_de, 0);
        chk("rst_pix_x", full_if.pix_x, 0);
        chk("rst_pix_y", full_if.pix_y, 0);
        chk("rst_frame_idx", full_if.frame_idx, 0);
        chk("rst_frame_start", full_if.frame_start, 0);

        i_res_n = 1'b1;
        do_pulse(4);
        chk("p0_de", full_if.lcd_de, 1);
        chk("p0_pix_x", full_if.pix_x, 0);
        chk("p0_pix_y", full_if.pix_y, 0);
        chk("p0_frame_start", full_if.frame_start, 1);
        chk("p0_lcd_clk", full_if.lcd_clk, 1);
        ce_pix = 1'b0;
        tick();
        chk("p0_fs_drop", full_if.frame_start, 0);
        chk("p0_clk_drop", full_if.lcd_clk, 0);
        chk("p0_de_hold", full_if.lcd_de, 1);

        run_line(4);
        for (int p = 526; p <= 1000; p++) do_pulse(4);
        chk("p1000_x", full_if.pix_x, 475);
        chk("p1000_y", full_if.pix_y, 1);

        // Asynchronous reset in the middle of a line
        ce_pix  = 1'b0;
        i_res_n = 1'b0;
        #2;
        chk("mid_rst_clk", full_if.lcd_clk, 0);
        chk("mid_rst_de", full_if.lcd_de, 0);
        chk("mid_rst_x", full_if.pix_x, 0);
        chk("mid_rst_y", full_if.pix_y, 0);
        chk("mid_rst_hsync", full_if.lcd_hsync, 1);
        tick();
        i_res_n = 1'b1;
        do_pulse(1);
        chk("rel_de", full_if.lcd_de, 1);
        chk("rel_x", full_if.pix_x, 0);
        chk("rel_y", full_if.pix_y, 0);
        chk("rel_fs", full_if.frame_start, 1);
        chk("rel_idx", full_if.frame_idx, 0);
        run_line(1);

        // Small raster: vertical timing and frame recurrence, ce_pix tied high
        ce_pix  = 1'b0;
        i_res_n = 1'b0;
        tick();
        i_res_n = 1'b1;
        ce_pix  = 1'b1;
        tick();
        chk("s_p0_fs", small_if.frame_start, 1);
        chk("s_p0_idx", small_if.frame_idx, 0);
        vbad = 0; debad = 0; fsbad = 0;
        for (int p = 1; p < 48; p++) begin
            tick();
            if (small_if.lcd_vsync !== ((p / 8) == 4 ? 1'b0 : 1'b1)) vbad++;
            if (small_if.lcd_de !== (((p % 8) < 4 && (p / 8) < 3) ? 1'b1 : 1'b0)) debad++;
            if (small_if.frame_start !== 1'b0) fsbad++;
        end
        chk("s_vsync_lines", vbad, 0);
        chk("s_de_lines", debad, 0);
        chk("s_fs_quiet", fsbad, 0);
        tick();
        chk("s_fs_recur", small_if.frame_start, 1);
        chk("s_idx_fe1", small_if.frame_idx, 0);

        // Sequencer, buttons released: advance every 4th frame-end
        step_frames(2, 0, "fe3");
        step_frames(1, 1, "fe4");
        step_frames(35, 9, "fe39");
        step_frames(1, 0, "fe40_wrap");

        // Party-hard: advance on every frame-end
        btn_a = 1'b0;
        step_frames(1, 1, "fast1");
        step_frames(4, 5, "fast5");

        // Two normal frame-ends leave hold at 2, then pause
        btn_a = 1'b1;
        step_frames(2, 5, "pre_pause");
        btn_b = 1'b0;
        step_frames(8, 5, "pause8");
        btn_a = 1'b0;
        step_frames(2, 5, "pause_fast");
        btn_a = 1'b1;
        btn_b = 1'b1;
        step_frames(1, 5, "resume1");
        step_frames(1, 6, "resume2");

        // Normal to fast with hold above HOLD_FAST advances at once
        step_frames(2, 6, "hold2");
        btn_a = 1'b0;
        step_frames(1, 7, "switch_fast");

        ce_pix = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
